// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and divisor helper.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned START_SAMPLE = 7;
  localparam int unsigned BIT_SAMPLE   = 15;
  localparam int unsigned DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// CPU-facing side of the UART receiver: held byte, status flags and read strobe.
interface uart_rx_unit_if;
  import uart_pkg::*;

  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (output rd, input rx_data, input rx_valid, input frame_err, input overrun);
  modport slave  (input rd, output rx_data, output rx_valid, output frame_err, output overrun);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks while enabled,
// counter held at zero while disabled so ticks align to the enable edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!en || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_unit.sv
// UART receive front-end: 2-FF synchronizer, 16x oversampled 8N1 framing with
// start-glitch rejection, held byte with sticky error/overrun. UART_RX_PARITY_EN selects 8E1.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_unit_if.slave  cpu
);
  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [3:0]           r_scnt;
  logic [2:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_commit;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (r_state != IDLE),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_scnt      <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_commit    <= 1'b0;
      r_par_bad   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_commit  <= 1'b0;

      // Commit is one clock after the stop sample; a read in that same cycle
      // takes the new byte and clears the sticky flags instead of overrunning.
      if (r_commit) begin
        if (!r_rx_valid) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else if (!cpu.rd) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data   <= r_shift;
          r_frame_err <= 1'b0;
          r_overrun   <= 1'b0;
        end
      end else if (cpu.rd) begin
        r_rx_valid  <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end

      // Error sets below come after the read clear so a set always wins.
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_scnt  <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_scnt == 4'(START_SAMPLE)) begin
              r_scnt <= '0;
              if (!r_rx_s) begin
                r_state   <= DATA;
                r_bitcnt  <= '0;
                r_par_bad <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_scnt == 4'(BIT_SAMPLE)) begin
              r_scnt   <= '0;
              r_shift  <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            if (r_scnt == 4'(BIT_SAMPLE)) begin
              r_scnt  <= '0;
              r_state <= STOP;
              if (^{r_shift, r_rx_s}) begin
                r_frame_err <= 1'b1;
                r_par_bad   <= 1'b1;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_scnt == 4'(BIT_SAMPLE)) begin
              r_scnt <= '0;
              if (r_rx_s) begin
                r_commit <= !r_par_bad;
                r_state  <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (r_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu.rx_data   = r_rx_data;
  assign cpu.rx_valid  = r_rx_valid;
  assign cpu.frame_err = r_frame_err;
  assign cpu.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit at 160 clk/bit: every change of the CPU-side
// outputs is matched against the next expected output tuple in a queue.
module tb_uart_rx_unit;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       fe;
    logic       ov;
  } out_t;

  typedef struct {
    out_t o;
    int   lat;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;

  uart_rx_unit_if u_if ();

  uart_rx_unit #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .cpu   (u_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  out_t prev = '0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_out(input logic [7:0] d, input logic v, input logic fe, input logic ov,
                            input int lat, input string name);
    exp_t e;
    e.o = {d, v, fe, ov};
    e.lat = lat;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic bit_wait();
    repeat (160) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int hold, input bit bad_par);
    @(posedge clk);
    #1;
    rx = 1'b0;
    start_cyc = cyc;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    bit_wait();
`else
    if (bad_par) rx = 1'b1;
`endif
    rx = stop_bit;
    bit_wait();
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1;
    u_if.rd = 1'b1;
    @(posedge clk);
    #1;
    u_if.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any change in the output tuple must match the next queued expectation.
  initial begin
    out_t cur;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.overrun};
        if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got data=%h valid=%b ferr=%b ovr=%b", cur.d, cur.v, cur.fe, cur.ov);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e.o) begin
              failures++;
              $display("FAIL %s got data=%h valid=%b ferr=%b ovr=%b want data=%h valid=%b ferr=%b ovr=%b",
                       e.name, cur.d, cur.v, cur.fe, cur.ov, e.o.d, e.o.v, e.o.fe, e.o.ov);
            end
            if (e.lat != 0) begin
              checks++;
              if (cyc - start_cyc != e.lat) begin
                failures++;
                $display("FAIL %s_latency got=%0d want=%0d", e.name, cyc - start_cyc, e.lat);
              end
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    failures++;
    $display("FAIL timeout got=%0d cycles want=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    u_if.rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.overrun} !== 11'h000) begin
      failures++;
      $display("FAIL reset_state got data=%h valid=%b ferr=%b ovr=%b want all 0",
               u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.overrun);
    end
    reset = 1'b1;
    prev = '0;
    mon_en = 1'b1;
    idle(20);

    // Basic receive with exact latency from start edge, then read.
    expect_out(8'hA5, 1, 0, 0, 1524, "rx_A5");
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    expect_out(8'hA5, 0, 0, 0, 0, "rd_A5");
    pulse_rd();
    idle(50);

    // Short low glitch must be rejected silently.
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rx = 1'b1;
    idle(300);
    expect_out(8'h3C, 1, 0, 0, 0, "rx_3C_after_glitch");
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    expect_out(8'h3C, 0, 0, 0, 0, "rd_3C");
    pulse_rd();
    idle(50);

    // Bad stop bit with line held low: one frame_err only.
    expect_out(8'h3C, 0, 1, 0, 0, "ferr_55");
    send_frame(8'h55, 1'b0, 3000, 1'b0);
    idle(200);
    expect_out(8'h12, 1, 1, 0, 0, "rx_12_ferr_sticky");
    send_frame(8'h12, 1'b1, 0, 1'b0);
    expect_out(8'h12, 0, 0, 0, 0, "rd_12");
    pulse_rd();
    idle(50);

    // Overrun: second byte dropped.
    expect_out(8'h01, 1, 0, 0, 0, "rx_01");
    send_frame(8'h01, 1'b1, 0, 1'b0);
    expect_out(8'h01, 1, 0, 1, 0, "overrun_02");
    send_frame(8'h02, 1'b1, 0, 1'b0);
    expect_out(8'h01, 0, 0, 0, 0, "rd_overrun");
    pulse_rd();
    idle(50);

    // Read on the exact commit cycle of a following byte.
    expect_out(8'h01, 1, 0, 0, 0, "rx_01_b");
    send_frame(8'h01, 1'b1, 0, 1'b0);
    expect_out(8'h02, 1, 0, 0, 0, "rd_on_commit_02");
    fork
      send_frame(8'h02, 1'b1, 0, 1'b0);
      begin
        @(posedge clk);
        #1;
        repeat (1523) @(posedge clk);
        #1;
        u_if.rd = 1'b1;
        @(posedge clk);
        #1;
        u_if.rd = 1'b0;
      end
    join
    expect_out(8'h02, 0, 0, 0, 0, "rd_02");
    pulse_rd();
    idle(50);

    // Reset in the middle of the data bits.
    fork
      send_frame(8'hFF, 1'b1, 0, 1'b0);
      begin
        repeat (600) @(posedge clk);
        #1;
        expect_out(8'h00, 0, 0, 0, 0, "reset_mid_frame");
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
      end
    join
    idle(50);
    expect_out(8'h81, 1, 0, 0, 0, "rx_81_after_reset");
    send_frame(8'h81, 1'b1, 0, 1'b0);
    expect_out(8'h81, 0, 0, 0, 0, "rd_81");
    pulse_rd();
    idle(50);

`ifdef UART_RX_PARITY_EN
    expect_out(8'h81, 0, 1, 0, 0, "parity_bad_07");
    send_frame(8'h07, 1'b1, 0, 1'b1);
    expect_out(8'h81, 0, 0, 0, 0, "rd_parity");
    pulse_rd();
    idle(50);
    expect_out(8'h07, 1, 0, 0, 0, "parity_good_07");
    send_frame(8'h07, 1'b1, 0, 1'b0);
    idle(50);
`endif

    idle(400);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d want=0 next=%s", exp_q.size(), exp_q[0].name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
